subset3_group_rule_lookup: RTL and testbench
============================================

Name: subset3_group_rule_lookup

Overview:
- Stage directly downstream of the subset3 group index checker.
- Takes the per-group table indices (G0–G3) and the 104-bit tuple, and reads one rule entry per group from an internal rule RAM. It masked-compares each entry against that group's hash-key field and returns the highest-priority hit.
- G4 table index and small/big flag pass through to the protocol-entry stage.
- Also owns the rule-update write port used by the update algorithm.

Parameters:
- INDEX_BIT_LEN, 11, width of per-group table index.
- PACKET_BIT_LEN, 104, tuple width.
- PRIO_BIT_LEN, 8, rule priority width (larger value = higher priority).
- RULE_ID_LEN, 16, rule identifier width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  high only in state IDLE.
- in_tuple  in  PACKET_BIT_LEN  tuple data.
- in_g0_index..in_g3_index  in  INDEX_BIT_LEN each  group indices.
- in_g4_table_index  in  12  pass-through.
- in_g4_big  in  1  pass-through.
- upd_valid  in  1  rule write request.
- upd_ready  out  1  low during INIT, else high.
- upd_group  in  2  target group 0–3.
- upd_index  in  INDEX_BIT_LEN  target entry.
- upd_key  in  32  rule key.
- upd_mask  in  32  rule mask; 1 = bit compared.
- upd_prio  in  PRIO_BIT_LEN  priority.
- upd_rule_id  in  RULE_ID_LEN  rule id.
- upd_entry_valid  in  1  0 deletes the entry.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts.
- out_hit  out  1  any group matched.
- out_rule_id  out  RULE_ID_LEN  winning rule id (0 on miss).
- out_prio  out  PRIO_BIT_LEN  winning priority (0 on miss).
- out_group  out  2  winning group (0 on miss).
- out_g4_table_index  out  12  registered copy of input.
- out_g4_big  out  1  registered copy of input.

Behaviour:
- Clock and reset: clk, one clock; rst synchronous active-high.
- Key fields, zero-extended to 32 bits:
  - G0 = tuple[31:0]
  - G1 = tuple[63:32]
  - G2 = {16'b0, tuple[79:64]}
  - G3 = {16'b0, tuple[95:80]}
- Rule RAM:
  - 4 × 2^INDEX_BIT_LEN entries, addressed {group, index}.
  - Entry = {valid, key, mask, prio, rule_id}.
  - One synchronous read port (1-cycle latency) and one write port.
  - Read and write to the same address in the same cycle returns old data.
- Write handshake: a write occurs on upd_valid && upd_ready, in any state except INIT.
- Match condition: entry.valid && (((field ^ key) & mask) == 0).
- Winner selection: a candidate replaces the current best only if it hits and its prio is strictly greater. Ties go to the lower group number.
- FSM states: INIT, IDLE, SCAN, LAST, OUT.
  - Reset → INIT.
  - INIT: write valid=0 to one address per cycle from 0 to 4·2^INDEX_BIT_LEN−1 (8192 cycles at default), then → IDLE.
  - IDLE: on in_valid at edge E0, latch tuple, indices and G4 fields; clear best; g=0; → SCAN.
  - SCAN:
    - Present read address {g, idx[g]} in the cycle after each edge.
    - From E2 on, fold in the data returned for g−1.
    - g increments each edge; after the g=3 address is issued (E4), → LAST.
  - LAST: fold in G3 data; register outputs; out_valid=1 after E5 (latency 5 edges from accept).
  - OUT: hold all outputs stable while !out_ready. On out_ready, out_valid=0 next cycle → IDLE.
  - No new request is accepted in the cycle out_valid drops.
- Reset values:
  - out_valid, out_hit, out_rule_id, out_prio, out_group, out_g4_* = 0.
  - in_ready = 0 and upd_ready = 0 (INIT).
- Reset mid-lookup or mid-INIT: abort; outputs zeroed next cycle; INIT restarts from address 0.
- An update to an entry during SCAN is visible to this lookup only if the write lands before that entry's read cycle.
- Index wrap: the address counter in INIT saturates at its final value; no wrap into IDLE traffic.

Decomposition:
- Package subset3_lookup_pkg holds:
  - group field slice constants (bit ranges per group);
  - NUM_GROUPS=4;
  - FSM state enum;
  - rule entry packed struct and its width.
- One sub-module, subset3_group_rule_ram: parameterised depth/width, sync read, read-first write. INIT clear is driven by the parent through the write port.

Test Plan:
- Reset then idle: rst 1 cycle → in_ready=0 for 8192 cycles, then 1; a lookup on empty RAM → out_hit=0, out_rule_id=0, out_valid exactly 5 edges after accept.
- Single hit: write G1 idx 5 key=0xC0A80001 mask=0xFFFFFF00 prio=3 id=0x0101; tuple[63:32]=0xC0A800FE, in_g1_index=5 → out_hit=1, id=0x0101, out_group=1.
- Priority and tie:
  - G0 prio 4 id 0xA and G2 prio 7 id 0xB both hit → id 0xB, group 2.
  - With G2 prio changed to 4 → id 0xA, group 0.
- Backpressure: hold out_ready=0 for 10 cycles → outputs stable, in_ready=0; release → out_valid falls next cycle, new request accepted one cycle later.
- Delete and same-cycle write: write upd_entry_valid=0 to a hit entry in the same cycle as its read → old (hit) result; the next lookup → miss.
- Reset mid-SCAN: assert rst at E2 → out_valid never rises; INIT restarts; a previously written rule is gone afterwards (miss).

Source files
------------

// File: rtl/subset3_lookup_pkg.sv
// Shared types and constants for the subset3 per-group rule lookup stage.
package subset3_lookup_pkg;

  localparam int unsigned NUM_GROUPS   = 4;
  localparam int unsigned GROUP_W      = 2;
  localparam int unsigned KEY_W        = 32;
  localparam int unsigned G4_IDX_W     = 12;
  localparam int unsigned PRIO_BIT_LEN = 8;
  localparam int unsigned RULE_ID_LEN  = 16;

  // Hash-key field of each group inside the tuple; G2/G3 are zero-extended.
  localparam int unsigned G0_LSB = 0;
  localparam int unsigned G0_W   = 32;
  localparam int unsigned G1_LSB = 32;
  localparam int unsigned G1_W   = 32;
  localparam int unsigned G2_LSB = 64;
  localparam int unsigned G2_W   = 16;
  localparam int unsigned G3_LSB = 80;
  localparam int unsigned G3_W   = 16;
  localparam int unsigned TUPLE_USED_W = G3_LSB + G3_W;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SCAN,
    ST_LAST,
    ST_OUT
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [KEY_W-1:0]        key;
    logic [KEY_W-1:0]        mask;
    logic [PRIO_BIT_LEN-1:0] prio;
    logic [RULE_ID_LEN-1:0]  rule_id;
  } rule_entry_t;

  localparam int unsigned RULE_ENTRY_W = $bits(rule_entry_t);

  function automatic logic [KEY_W-1:0] group_field(input logic [TUPLE_USED_W-1:0] tuple,
                                                   input logic [GROUP_W-1:0] grp);
    logic [KEY_W-1:0] field;
    case (grp)
      2'd0:    field = KEY_W'(tuple[G0_LSB +: G0_W]);
      2'd1:    field = KEY_W'(tuple[G1_LSB +: G1_W]);
      2'd2:    field = KEY_W'(tuple[G2_LSB +: G2_W]);
      default: field = KEY_W'(tuple[G3_LSB +: G3_W]);
    endcase
    return field;
  endfunction

  // Mask bit set means that bit of the field must equal the key.
  function automatic logic rule_match(input rule_entry_t entry, input logic [KEY_W-1:0] field);
    return entry.valid && (((field ^ entry.key) & entry.mask) == '0);
  endfunction

endpackage

// File: rtl/subset3_group_rule_ram.sv
// Single-clock rule RAM: one synchronous read port, one write port, read-first on collision.
module subset3_group_rule_ram #(
  parameter  int unsigned DEPTH  = 8192,
  parameter  int unsigned DATA_W = 89,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/subset3_group_rule_lookup.sv
// Reads one rule per group (G0..G3), masked-compares against the tuple key fields and
// reports the highest-priority hit; owns the rule-update write port and RAM clear.
module subset3_group_rule_lookup
  import subset3_lookup_pkg::*;
#(
  parameter int unsigned INDEX_BIT_LEN  = 11,
  parameter int unsigned PACKET_BIT_LEN = 104
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PACKET_BIT_LEN-1:0] in_tuple,
  input  logic [INDEX_BIT_LEN-1:0]  in_g0_index,
  input  logic [INDEX_BIT_LEN-1:0]  in_g1_index,
  input  logic [INDEX_BIT_LEN-1:0]  in_g2_index,
  input  logic [INDEX_BIT_LEN-1:0]  in_g3_index,
  input  logic [G4_IDX_W-1:0]       in_g4_table_index,
  input  logic                      in_g4_big,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [GROUP_W-1:0]        upd_group,
  input  logic [INDEX_BIT_LEN-1:0]  upd_index,
  input  logic [KEY_W-1:0]          upd_key,
  input  logic [KEY_W-1:0]          upd_mask,
  input  logic [PRIO_BIT_LEN-1:0]   upd_prio,
  input  logic [RULE_ID_LEN-1:0]    upd_rule_id,
  input  logic                      upd_entry_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_hit,
  output logic [RULE_ID_LEN-1:0]    out_rule_id,
  output logic [PRIO_BIT_LEN-1:0]   out_prio,
  output logic [GROUP_W-1:0]        out_group,
  output logic [G4_IDX_W-1:0]       out_g4_table_index,
  output logic                      out_g4_big
);

  localparam int unsigned ADDR_W    = GROUP_W + INDEX_BIT_LEN;
  localparam int unsigned RAM_DEPTH = NUM_GROUPS << INDEX_BIT_LEN;
  localparam logic [ADDR_W-1:0]  INIT_LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [GROUP_W-1:0] LAST_GRP       = GROUP_W'(NUM_GROUPS - 1);

  state_e                                    state_q, state_d;
  logic [GROUP_W-1:0]                        grp_q, grp_d;
  logic [ADDR_W-1:0]                         init_addr_q, init_addr_d;
  logic [TUPLE_USED_W-1:0]                   tuple_q, tuple_d;
  logic [NUM_GROUPS-1:0][INDEX_BIT_LEN-1:0]  idx_q, idx_d;
  logic [G4_IDX_W-1:0]                       g4_idx_q, g4_idx_d;
  logic                                      g4_big_q, g4_big_d;
  logic                                      best_hit_q, best_hit_d;
  logic [PRIO_BIT_LEN-1:0]                   best_prio_q, best_prio_d;
  logic [RULE_ID_LEN-1:0]                    best_id_q, best_id_d;
  logic [GROUP_W-1:0]                        best_grp_q, best_grp_d;
  logic                                      in_ready_q, in_ready_d;
  logic                                      upd_ready_q, upd_ready_d;
  logic                                      out_valid_q, out_valid_d;
  logic                                      out_hit_q, out_hit_d;
  logic [RULE_ID_LEN-1:0]                    out_rule_id_q, out_rule_id_d;
  logic [PRIO_BIT_LEN-1:0]                   out_prio_q, out_prio_d;
  logic [GROUP_W-1:0]                        out_group_q, out_group_d;
  logic [G4_IDX_W-1:0]                       out_g4_idx_q, out_g4_idx_d;
  logic                                      out_g4_big_q, out_g4_big_d;

  logic                    ram_wr_en;
  logic [ADDR_W-1:0]       ram_wr_addr;
  rule_entry_t             ram_wr_data;
  logic [ADDR_W-1:0]       ram_rd_addr;
  logic [RULE_ENTRY_W-1:0] ram_rd_data;
  rule_entry_t             rd_entry;
  logic [GROUP_W-1:0]      fold_grp;
  logic                    fold_take;
  logic                    unused_tuple_hi;

  assign unused_tuple_hi = ^in_tuple[PACKET_BIT_LEN-1:TUPLE_USED_W];

  subset3_group_rule_ram #(
    .DEPTH  (RAM_DEPTH),
    .DATA_W (RULE_ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  assign ram_rd_addr = {grp_q, idx_q[grp_q]};

  // RAM data arriving now belongs to the group addressed one cycle earlier.
  always_comb begin
    fold_grp  = (state_q == ST_LAST) ? grp_q : grp_q - GROUP_W'(1);
    rd_entry  = rule_entry_t'(ram_rd_data);
    fold_take = rule_match(rd_entry, group_field(tuple_q, fold_grp)) &&
                (!best_hit_q || (rd_entry.prio > best_prio_q));
  end

  always_comb begin
    state_d       = state_q;
    grp_d         = grp_q;
    init_addr_d   = init_addr_q;
    tuple_d       = tuple_q;
    idx_d         = idx_q;
    g4_idx_d      = g4_idx_q;
    g4_big_d      = g4_big_q;
    best_hit_d    = best_hit_q;
    best_prio_d   = best_prio_q;
    best_id_d     = best_id_q;
    best_grp_d    = best_grp_q;
    out_valid_d   = out_valid_q;
    out_hit_d     = out_hit_q;
    out_rule_id_d = out_rule_id_q;
    out_prio_d    = out_prio_q;
    out_group_d   = out_group_q;
    out_g4_idx_d  = out_g4_idx_q;
    out_g4_big_d  = out_g4_big_q;

    ram_wr_en           = upd_valid && upd_ready_q;
    ram_wr_addr         = {upd_group, upd_index};
    ram_wr_data.valid   = upd_entry_valid;
    ram_wr_data.key     = upd_key;
    ram_wr_data.mask    = upd_mask;
    ram_wr_data.prio    = upd_prio;
    ram_wr_data.rule_id = upd_rule_id;

    case (state_q)
      ST_INIT: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = init_addr_q;
        ram_wr_data = '0;
        if (init_addr_q == INIT_LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          init_addr_d = init_addr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          tuple_d     = in_tuple[TUPLE_USED_W-1:0];
          idx_d       = {in_g3_index, in_g2_index, in_g1_index, in_g0_index};
          g4_idx_d    = in_g4_table_index;
          g4_big_d    = in_g4_big;
          best_hit_d  = 1'b0;
          best_prio_d = '0;
          best_id_d   = '0;
          best_grp_d  = '0;
          grp_d       = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (grp_q != '0 && fold_take) begin
          best_hit_d  = 1'b1;
          best_prio_d = rd_entry.prio;
          best_id_d   = rd_entry.rule_id;
          best_grp_d  = fold_grp;
        end
        if (grp_q == LAST_GRP) begin
          state_d = ST_LAST;
        end else begin
          grp_d = grp_q + GROUP_W'(1);
        end
      end
      ST_LAST: begin
        out_valid_d   = 1'b1;
        out_hit_d     = fold_take ? 1'b1             : best_hit_q;
        out_prio_d    = fold_take ? rd_entry.prio    : best_prio_q;
        out_rule_id_d = fold_take ? rd_entry.rule_id : best_id_q;
        out_group_d   = fold_take ? fold_grp         : best_grp_q;
        out_g4_idx_d  = g4_idx_q;
        out_g4_big_d  = g4_big_q;
        state_d       = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    upd_ready_d = (state_d != ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      grp_q         <= '0;
      init_addr_q   <= '0;
      tuple_q       <= '0;
      idx_q         <= '0;
      g4_idx_q      <= '0;
      g4_big_q      <= 1'b0;
      best_hit_q    <= 1'b0;
      best_prio_q   <= '0;
      best_id_q     <= '0;
      best_grp_q    <= '0;
      in_ready_q    <= 1'b0;
      upd_ready_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_hit_q     <= 1'b0;
      out_rule_id_q <= '0;
      out_prio_q    <= '0;
      out_group_q   <= '0;
      out_g4_idx_q  <= '0;
      out_g4_big_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grp_q         <= grp_d;
      init_addr_q   <= init_addr_d;
      tuple_q       <= tuple_d;
      idx_q         <= idx_d;
      g4_idx_q      <= g4_idx_d;
      g4_big_q      <= g4_big_d;
      best_hit_q    <= best_hit_d;
      best_prio_q   <= best_prio_d;
      best_id_q     <= best_id_d;
      best_grp_q    <= best_grp_d;
      in_ready_q    <= in_ready_d;
      upd_ready_q   <= upd_ready_d;
      out_valid_q   <= out_valid_d;
      out_hit_q     <= out_hit_d;
      out_rule_id_q <= out_rule_id_d;
      out_prio_q    <= out_prio_d;
      out_group_q   <= out_group_d;
      out_g4_idx_q  <= out_g4_idx_d;
      out_g4_big_q  <= out_g4_big_d;
    end
  end

  assign in_ready           = in_ready_q;
  assign upd_ready          = upd_ready_q;
  assign out_valid          = out_valid_q;
  assign out_hit            = out_hit_q;
  assign out_rule_id        = out_rule_id_q;
  assign out_prio           = out_prio_q;
  assign out_group          = out_group_q;
  assign out_g4_table_index = out_g4_idx_q;
  assign out_g4_big         = out_g4_big_q;

endmodule

// File: tb/tb_subset3_group_rule_lookup.sv
// Bench for subset3_group_rule_lookup: randomized lookups against an array-based rule model.
module tb_subset3_group_rule_lookup;

  localparam int INIT_CYCLES = 8192;

  typedef struct packed {
    logic        hit;
    logic [15:0] id;
    logic [7:0]  prio;
    logic [1:0]  grp;
    logic [11:0] g4i;
    logic        g4b;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [103:0] in_tuple;
  logic [10:0]  in_g0_index, in_g1_index, in_g2_index, in_g3_index;
  logic [11:0]  in_g4_table_index;
  logic         in_g4_big;
  logic         upd_valid, upd_ready;
  logic [1:0]   upd_group;
  logic [10:0]  upd_index;
  logic [31:0]  upd_key, upd_mask;
  logic [7:0]   upd_prio;
  logic [15:0]  upd_rule_id;
  logic         upd_entry_valid;
  logic         out_valid, out_ready, out_hit;
  logic [15:0]  out_rule_id;
  logic [7:0]   out_prio;
  logic [1:0]   out_group;
  logic [11:0]  out_g4_table_index;
  logic         out_g4_big;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid [4][2048];
  logic [31:0] m_key   [4][2048];
  logic [31:0] m_mask  [4][2048];
  logic [7:0]  m_prio  [4][2048];
  logic [15:0] m_id    [4][2048];

  always #5 clk = ~clk;

  subset3_group_rule_lookup #(.INDEX_BIT_LEN(11), .PACKET_BIT_LEN(104)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tuple(in_tuple),
    .in_g0_index(in_g0_index), .in_g1_index(in_g1_index),
    .in_g2_index(in_g2_index), .in_g3_index(in_g3_index),
    .in_g4_table_index(in_g4_table_index), .in_g4_big(in_g4_big),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_group(upd_group),
    .upd_index(upd_index), .upd_key(upd_key), .upd_mask(upd_mask),
    .upd_prio(upd_prio), .upd_rule_id(upd_rule_id), .upd_entry_valid(upd_entry_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_rule_id(out_rule_id), .out_prio(out_prio), .out_group(out_group),
    .out_g4_table_index(out_g4_table_index), .out_g4_big(out_g4_big)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int field_lsb(input int g);
    return (g < 2) ? 32 * g : 64 + 16 * (g - 2);
  endfunction

  function automatic int field_width(input int g);
    return (g < 2) ? 32 : 16;
  endfunction

  function automatic logic [31:0] key_field(input logic [103:0] t, input int g);
    logic [103:0] s;
    s = t >> field_lsb(g);
    return (field_width(g) == 32) ? s[31:0] : {16'h0, s[15:0]};
  endfunction

  function automatic logic [103:0] put_field(input logic [103:0] t, input int g, input logic [31:0] v);
    logic [103:0] r;
    r = t;
    for (int b = 0; b < field_width(g); b++) r[field_lsb(g) + b] = v[b];
    return r;
  endfunction

  function automatic logic [103:0] rand_tuple();
    return 104'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Highest priority wins; scanning groups upward with strict '>' keeps the lower group on ties.
  function automatic res_t model_lookup(input logic [103:0] t, input logic [10:0] ix [4],
                                        input logic [11:0] g4i, input logic g4b);
    res_t r;
    r = '0;
    for (int g = 0; g < 4; g++) begin
      int i;
      logic [31:0] f;
      i = int'(ix[g]);
      f = key_field(t, g);
      if (m_valid[g][i] && (((f ^ m_key[g][i]) & m_mask[g][i]) == 32'h0) &&
          (!r.hit || m_prio[g][i] > r.prio)) begin
        r.hit  = 1'b1;
        r.id   = m_id[g][i];
        r.prio = m_prio[g][i];
        r.grp  = 2'(g);
      end
    end
    r.g4i = g4i;
    r.g4b = g4b;
    return r;
  endfunction

  task automatic model_clear();
    for (int g = 0; g < 4; g++)
      for (int i = 0; i < 2048; i++) m_valid[g][i] = 1'b0;
  endtask

  task automatic model_write(input int g, input int i, input logic [31:0] key, input logic [31:0] mask,
                             input logic [7:0] prio, input logic [15:0] id, input logic v);
    m_valid[g][i] = v;
    m_key[g][i]   = key;
    m_mask[g][i]  = mask;
    m_prio[g][i]  = prio;
    m_id[g][i]    = id;
  endtask

  task automatic prep_upd(input int g, input int i, input logic [31:0] key, input logic [31:0] mask,
                          input logic [7:0] prio, input logic [15:0] id, input logic v);
    upd_group       = 2'(g);
    upd_index       = 11'(i);
    upd_key         = key;
    upd_mask        = mask;
    upd_prio        = prio;
    upd_rule_id     = id;
    upd_entry_valid = v;
  endtask

  task automatic do_write(input int g, input int i, input logic [31:0] key, input logic [31:0] mask,
                          input logic [7:0] prio, input logic [15:0] id, input logic v);
    prep_upd(g, i, key, mask, prio, id, v);
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    model_write(g, i, key, mask, prio, id, v);
  endtask

  // Issues one request; optionally pulses the prepared update in the cycle after acceptance.
  task automatic run_lookup(input logic [103:0] t, input logic [10:0] ix [4], input logic [11:0] g4i,
                            input logic g4b, input bit wr_after_accept, output res_t r, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    in_valid          = 1'b1;
    in_tuple          = t;
    in_g0_index       = ix[0];
    in_g1_index       = ix[1];
    in_g2_index       = ix[2];
    in_g3_index       = ix[3];
    in_g4_table_index = g4i;
    in_g4_big         = g4b;
    tick();
    in_valid          = 1'b0;
    in_tuple          = rand_tuple();
    in_g0_index       = 11'($urandom);
    in_g1_index       = 11'($urandom);
    in_g2_index       = 11'($urandom);
    in_g3_index       = 11'($urandom);
    in_g4_table_index = 12'($urandom);
    in_g4_big         = 1'($urandom);
    lat = 0;
    if (wr_after_accept) begin
      upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      lat = 1;
    end
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    r = {out_hit, out_rule_id, out_prio, out_group, out_g4_table_index, out_g4_big};
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int   cnt;
    res_t r, exp;
    int   lat;
    logic [10:0] ix [4];
    logic [103:0] t;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({out_valid, out_hit, out_rule_id, out_prio, out_group, out_g4_table_index, out_g4_big,
         in_ready, upd_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b hit=%b id=%h prio=%h grp=%h g4=%h/%b in_rdy=%b upd_rdy=%b, expected all zero",
               out_valid, out_hit, out_rule_id, out_prio, out_group, out_g4_table_index, out_g4_big,
               in_ready, upd_ready);
    end
    cnt = 0;
    while (!in_ready && cnt < 9000) begin
      tick();
      cnt++;
    end
    n_tests++;
    if (cnt !== INIT_CYCLES) begin
      n_fail++;
      $display("FAIL init_length: in_ready rose after %0d cycles, expected %0d", cnt, INIT_CYCLES);
    end
    n_tests++;
    if (upd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL upd_ready_after_init: got %b expected 1", upd_ready);
    end
    model_clear();
    for (int k = 0; k < 3; k++) begin
      t = rand_tuple();
      for (int g = 0; g < 4; g++) ix[g] = 11'($urandom);
      exp = model_lookup(t, ix, 12'(k + 1), 1'(k));
      run_lookup(t, ix, 12'(k + 1), 1'(k), 1'b0, r, lat);
      n_tests++;
      if (r !== exp || r.hit !== 1'b0 || r.id !== 16'h0) begin
        n_fail++;
        $display("FAIL empty_lookup[%0d]: got %h expected %h", k, r, exp);
      end
      n_tests++;
      if (lat !== 5) begin
        n_fail++;
        $display("FAIL empty_latency[%0d]: got %0d edges expected 5", k, lat);
      end
      release_out();
    end
  endtask

  task automatic test_single_hit();
    res_t r, exp;
    int lat;
    logic [10:0] ix [4];
    logic [103:0] t;
    do_write(1, 5, 32'hC0A80001, 32'hFFFFFF00, 8'd3, 16'h0101, 1'b1);
    t = put_field(rand_tuple(), 1, 32'hC0A800FE);
    ix[0] = 11'd1500; ix[1] = 11'd5; ix[2] = 11'd1501; ix[3] = 11'd1502;
    exp = model_lookup(t, ix, 12'hABC, 1'b1);
    run_lookup(t, ix, 12'hABC, 1'b1, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || r.hit !== 1'b1 || r.id !== 16'h0101 || r.grp !== 2'd1) begin
      n_fail++;
      $display("FAIL single_hit: got %h expected %h", r, exp);
    end
    release_out();
    t = put_field(t, 1, 32'hC0A900FE);
    exp = model_lookup(t, ix, 12'h123, 1'b0);
    run_lookup(t, ix, 12'h123, 1'b0, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || r.hit !== 1'b0) begin
      n_fail++;
      $display("FAIL single_masked_miss: got %h expected %h", r, exp);
    end
    release_out();
  endtask

  task automatic test_priority();
    res_t r, exp;
    int lat;
    logic [10:0] ix [4];
    logic [103:0] t;
    logic [31:0] k0, k2;
    int i0, i2;
    i0 = $urandom_range(200, 299);
    i2 = $urandom_range(200, 299);
    k0 = $urandom;
    k2 = {16'h0, 16'($urandom)};
    do_write(0, i0, k0, 32'hFFFFFFFF, 8'd4, 16'h000A, 1'b1);
    do_write(2, i2, k2, 32'h0000FFFF, 8'd7, 16'h000B, 1'b1);
    t = put_field(put_field(rand_tuple(), 0, k0), 2, k2);
    ix[0] = 11'(i0); ix[1] = 11'd1600; ix[2] = 11'(i2); ix[3] = 11'd1601;
    exp = model_lookup(t, ix, 12'h055, 1'b0);
    run_lookup(t, ix, 12'h055, 1'b0, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || r.id !== 16'h000B || r.grp !== 2'd2 || r.prio !== 8'd7) begin
      n_fail++;
      $display("FAIL prio_higher_wins: got %h expected %h", r, exp);
    end
    release_out();
    do_write(2, i2, k2, 32'h0000FFFF, 8'd4, 16'h000B, 1'b1);
    exp = model_lookup(t, ix, 12'h0AA, 1'b1);
    run_lookup(t, ix, 12'h0AA, 1'b1, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || r.id !== 16'h000A || r.grp !== 2'd0) begin
      n_fail++;
      $display("FAIL prio_tie_lower_group: got %h expected %h", r, exp);
    end
    release_out();
  endtask

  task automatic test_random();
    res_t r, exp;
    int lat, hits;
    logic [10:0] ix [4];
    logic [103:0] t;
    logic [31:0] mask;
    hits = 0;
    for (int it = 0; it < 40; it++) begin
      for (int w = 0; w < $urandom_range(1, 3); w++) begin
        int g;
        g = $urandom_range(0, 3);
        mask = $urandom & $urandom;
        if (g >= 2 && $urandom_range(0, 1) == 1) mask = mask & 32'h0000FFFF;
        do_write(g, $urandom_range(0, 3), $urandom, mask, 8'($urandom_range(0, 3)),
                 16'($urandom), 1'($urandom_range(0, 7) != 0));
      end
      t = rand_tuple();
      for (int g = 0; g < 4; g++) begin
        ix[g] = 11'($urandom_range(0, 3));
        if ($urandom_range(0, 2) != 0) t = put_field(t, g, m_key[g][int'(ix[g])]);
      end
      exp = model_lookup(t, ix, 12'($urandom), 1'($urandom));
      run_lookup(t, ix, exp.g4i, exp.g4b, 1'b0, r, lat);
      if (exp.hit) hits++;
      n_tests++;
      if (r !== exp || lat !== 5) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h lat %0d expected %h lat 5", it, r, lat, exp);
      end
      release_out();
    end
    n_tests++;
    if (hits == 0) begin
      n_fail++;
      $display("FAIL random_coverage: got %0d hits expected at least 1", hits);
    end
  endtask

  task automatic test_backpressure();
    res_t r, held, exp;
    int lat;
    bit stable;
    logic [10:0] ix [4];
    logic [103:0] t;
    logic [31:0] k;
    k = $urandom;
    do_write(1, 9, k, 32'hFFFFFFFF, 8'd200, 16'h5A5A, 1'b1);
    t = put_field(rand_tuple(), 1, k);
    ix[0] = 11'd1700; ix[1] = 11'd9; ix[2] = 11'd1701; ix[3] = 11'd1702;
    exp = model_lookup(t, ix, 12'hFED, 1'b1);
    run_lookup(t, ix, 12'hFED, 1'b1, 1'b0, held, lat);
    n_tests++;
    if (held !== exp) begin
      n_fail++;
      $display("FAIL bp_result: got %h expected %h", held, exp);
    end
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      r = {out_hit, out_rule_id, out_prio, out_group, out_g4_table_index, out_g4_big};
      if (out_valid !== 1'b1 || r !== held || in_ready !== 1'b0) stable = 1'b0;
    end
    n_tests++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: outputs changed or in_ready rose while stalled (got %h v=%b rdy=%b, held %h)",
               r, out_valid, in_ready, held);
    end
    release_out();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    exp = model_lookup(t, ix, 12'h321, 1'b0);
    run_lookup(t, ix, 12'h321, 1'b0, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || lat !== 5) begin
      n_fail++;
      $display("FAIL bp_back_to_back: got %h lat %0d expected %h lat 5", r, lat, exp);
    end
    release_out();
  endtask

  task automatic test_same_cycle_write();
    res_t r, exp;
    int lat;
    logic [10:0] ix [4];
    logic [103:0] t;
    logic [31:0] k0, k2;
    k0 = $urandom;
    k2 = {16'h0, 16'($urandom)};
    do_write(0, 1900, k0, 32'hFFFFFFFF, 8'd1, 16'h0C0C, 1'b1);
    do_write(2, 2040, k2, 32'h0000FFFF, 8'd2, 16'h0D0D, 1'b1);
    // G0 delete lands on the same edge as the G0 read: old data is returned.
    t = put_field(rand_tuple(), 0, k0);
    ix[0] = 11'd1900; ix[1] = 11'd2047; ix[2] = 11'd2047; ix[3] = 11'd2047;
    exp = model_lookup(t, ix, 12'h001, 1'b0);
    prep_upd(0, 1900, 32'h0, 32'h0, 8'h0, 16'h0, 1'b0);
    run_lookup(t, ix, 12'h001, 1'b0, 1'b1, r, lat);
    model_write(0, 1900, 32'h0, 32'h0, 8'h0, 16'h0, 1'b0);
    n_tests++;
    if (r !== exp || r.hit !== 1'b1 || r.id !== 16'h0C0C || lat !== 5) begin
      n_fail++;
      $display("FAIL collide_old_data: got %h lat %0d expected %h lat 5", r, lat, exp);
    end
    release_out();
    exp = model_lookup(t, ix, 12'h002, 1'b1);
    run_lookup(t, ix, 12'h002, 1'b1, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || r.hit !== 1'b0) begin
      n_fail++;
      $display("FAIL delete_then_miss: got %h expected %h", r, exp);
    end
    release_out();
    // G2 delete lands before the G2 read, so this lookup already misses.
    t = put_field(rand_tuple(), 2, k2);
    ix[0] = 11'd2047; ix[1] = 11'd2047; ix[2] = 11'd2040; ix[3] = 11'd2047;
    prep_upd(2, 2040, 32'h0, 32'h0, 8'h0, 16'h0, 1'b0);
    model_write(2, 2040, 32'h0, 32'h0, 8'h0, 16'h0, 1'b0);
    exp = model_lookup(t, ix, 12'h003, 1'b0);
    run_lookup(t, ix, 12'h003, 1'b0, 1'b1, r, lat);
    n_tests++;
    if (r !== exp || r.hit !== 1'b0) begin
      n_fail++;
      $display("FAIL early_delete_visible: got %h expected %h", r, exp);
    end
    release_out();
  endtask

  task automatic test_reset_mid_scan();
    res_t r, exp;
    int lat, cnt;
    bit seen_valid;
    logic [10:0] ix [4];
    logic [103:0] t;
    logic [31:0] k;
    k = {16'h0, 16'($urandom)};
    do_write(3, 7, k, 32'h0000FFFF, 8'd9, 16'h0033, 1'b1);
    t = put_field(rand_tuple(), 3, k);
    ix[0] = 11'd2046; ix[1] = 11'd2046; ix[2] = 11'd2046; ix[3] = 11'd7;
    exp = model_lookup(t, ix, 12'h777, 1'b1);
    run_lookup(t, ix, 12'h777, 1'b1, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || r.hit !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_hit: got %h expected %h", r, exp);
    end
    release_out();
    in_valid = 1'b1;
    in_tuple = t;
    in_g0_index = ix[0]; in_g1_index = ix[1]; in_g2_index = ix[2]; in_g3_index = ix[3];
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({out_valid, out_hit, out_rule_id, out_prio, out_group, out_g4_table_index, out_g4_big,
         in_ready, upd_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_scan_reset_zero: got v=%b hit=%b id=%h prio=%h grp=%h g4=%h/%b, expected all zero",
               out_valid, out_hit, out_rule_id, out_prio, out_group, out_g4_table_index, out_g4_big);
    end
    cnt = 0;
    seen_valid = 1'b0;
    while (!in_ready && cnt < 9000) begin
      tick();
      cnt++;
      if (out_valid) seen_valid = 1'b1;
    end
    n_tests++;
    if (seen_valid !== 1'b0 || cnt !== INIT_CYCLES) begin
      n_fail++;
      $display("FAIL mid_scan_reinit: got out_valid_seen=%b init=%0d cycles expected 0 and %0d",
               seen_valid, cnt, INIT_CYCLES);
    end
    model_clear();
    exp = model_lookup(t, ix, 12'h778, 1'b0);
    run_lookup(t, ix, 12'h778, 1'b0, 1'b0, r, lat);
    n_tests++;
    if (r !== exp || r.hit !== 1'b0 || lat !== 5) begin
      n_fail++;
      $display("FAIL rule_cleared_by_reset: got %h lat %0d expected %h lat 5", r, lat, exp);
    end
    release_out();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_tuple = '0;
    in_g0_index = '0; in_g1_index = '0; in_g2_index = '0; in_g3_index = '0;
    in_g4_table_index = '0; in_g4_big = 1'b0;
    upd_valid = 1'b0; upd_group = '0; upd_index = '0; upd_key = '0; upd_mask = '0;
    upd_prio = '0; upd_rule_id = '0; upd_entry_valid = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_hit();
    test_priority();
    test_random();
    test_backpressure();
    test_same_cycle_write();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
